// File: rtl/vedic_urdhva_colser_mult.sv
// Column-serial Urdhva-Tiryagbhyam unsigned multiplier: one product bit per clock,
// column 0 first, with the column sum bit built from a NOR2-only XOR chain.
module vedic_urdhva_colser_mult #(
  parameter int N  = 4,
  parameter int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int KW = $clog2(2 * N);
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [N-1:0]     a_q, b_q;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    carry_q, carry_d;
  logic [2*N-1:0]   product_q;

  logic [3*N-1:0]   bExt;
  logic [N-1:0]     bWin, bDiag, ppVec, ppShift;
  logic [SW-1:0]    colSum;
  logic             colBit;

  function automatic logic nor2(input logic x, input logic y);
    return ~(x | y);
  endfunction

  function automatic logic norXor(input logic x, input logic y);
    logic n1, n2, n3, n4;
    n1 = nor2(x, y);
    n2 = nor2(x, n1);
    n3 = nor2(y, n1);
    n4 = nor2(n2, n3);
    return nor2(n4, n4);
  endfunction

  // Zero-padded B shifted by the column index lines up b[k-i] with a[i];
  // out-of-range diagonal terms fall onto the padding and contribute nothing.
  always_comb begin
    bExt    = {{N{1'b0}}, b_q, {N{1'b0}}};
    bWin    = N'(bExt >> (k_q + KW'(1)));
    bDiag   = {<<{bWin}};
    ppVec   = a_q & bDiag;
    colSum  = SW'($countones(ppVec)) + SW'(carry_q);
    carry_d = CW'(colSum >> 1);
    colBit  = carry_q[0];
    ppShift = ppVec;
    for (int i = 0; i < N; i++) begin
      colBit  = norXor(colBit, ppShift[0]);
      ppShift = ppShift >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      carry_q   <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            k_q       <= '0;
            carry_q   <= '0;
            product_q <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          product_q[k_q] <= colBit;
          carry_q        <= carry_d;
          k_q            <= k_q + KW'(1);
          // The final carry is at most 1, so it is exactly the top product bit.
          if (k_q == KW'(2 * N - 2)) begin
            product_q[2*N-1] <= carry_d[0];
            state_q          <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule
